// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, long-press
// detection and auto-repeat. All outputs are registered.
module button_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic held,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_P  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic          SYNC_IDLE = (ACTIVE_LOW != 0);

  // Every period must be at least one cycle or the terminal counts underflow.
  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_debounce: all cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } state_t;

  logic          r_sync1, r_sync2;
  logic          w_raw;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_db_cnt, w_db_nxt;
  logic [CW-1:0] r_hold_cnt, w_hold_nxt;
  logic [CW-1:0] r_rep_cnt, w_rep_nxt;
  logic          r_long, w_long_nxt;
  logic          w_press, w_rel, w_rep;
  logic          r_press_q, r_rel_q, r_rep_q;

  // Two-flop synchroniser; resets to the released pad level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, counter updates and event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_long_nxt  = r_long;
    w_press     = 1'b0;
    w_rel       = 1'b0;
    w_rep       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_raw) begin
          w_state_nxt = S_PRESS_WAIT;
          w_db_nxt    = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_raw) begin
          w_state_nxt = S_IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_press     = 1'b1;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
          w_long_nxt  = 1'b0;
        end else begin
          w_db_nxt = r_db_cnt + ONE;
        end
      end
      S_HELD: begin
        if (!w_raw) begin
          w_state_nxt = S_REL_WAIT;
          w_db_nxt    = '0;
        end else if (!r_long) begin
          // hold_cnt parks at its terminal value once long_press is set
          if (r_hold_cnt == LONG_LAST) begin
            w_long_nxt = 1'b1;
            w_rep      = 1'b1;
            w_rep_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + ONE;
          end
        end else if (r_rep_cnt == REP_LAST) begin
          w_rep     = 1'b1;
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + ONE;
        end
      end
      S_REL_WAIT: begin
        // hold/repeat counters stay frozen so a glitch resumes where it left off
        if (w_raw) begin
          w_state_nxt = S_HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_rel       = 1'b1;
          w_long_nxt  = 1'b0;
        end else begin
          w_db_nxt = r_db_cnt + ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, long-press flag and event capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_long     <= 1'b0;
      r_press_q  <= 1'b0;
      r_rel_q    <= 1'b0;
      r_rep_q    <= 1'b0;
    end else begin
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_long     <= w_long_nxt;
      r_press_q  <= w_press;
      r_rel_q    <= w_rel;
      r_rep_q    <= w_rep;
    end
  end

  // Output register stage: strobes and levels line up on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= r_press_q;
      release_pulse <= r_rel_q;
      repeat_pulse  <= r_rep_q;
      held          <= (r_state == S_HELD) || (r_state == S_REL_WAIT);
      long_press    <= r_long;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: run-length reference model compared every cycle,
// directed scenarios with literal latency checks, then random button activity.
module tb_button_debounce;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clock = 1'b0;
  logic reset_n;
  logic btn_in;
  logic press_pulse, release_pulse, held, long_press, repeat_pulse;

  button_debounce #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clock(clock), .reset_n(reset_n), .btn_in(btn_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .held(held),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pressed level delayed two edges; a level change is
  // accepted after it persists for D+1 consecutive edges. While accepted as
  // pressed, each edge with the button still down counts toward long press
  // (edge L) and repeats every R counted edges after that. Outputs show the
  // previous edge's result.
  bit s1, s2, deb, lng, i_press, i_rel, i_rep;
  bit e_press, e_rel, e_rep, e_held, e_long;
  int run, cnt;
  bit r;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 = 0; s2 = 0; deb = 0; lng = 0; run = 0; cnt = 0;
      i_press = 0; i_rel = 0; i_rep = 0;
      e_press = 0; e_rel = 0; e_rep = 0; e_held = 0; e_long = 0;
    end else begin
      e_press = i_press; e_rel = i_rel; e_rep = i_rep; e_held = deb; e_long = lng;
      i_press = 0; i_rel = 0; i_rep = 0;
      r = s2;
      if (!deb) begin
        if (r) begin
          run++;
          if (run == D + 1) begin deb = 1; run = 0; cnt = 0; i_press = 1; end
        end else run = 0;
      end else begin
        if (!r) begin
          run++;
          if (run == D + 1) begin deb = 0; run = 0; lng = 0; i_rel = 1; end
        end else if (run > 0) begin
          run = 0;
        end else begin
          cnt++;
          if (cnt == L) begin lng = 1; i_rep = 1; end
          else if (cnt > L && (cnt - L) % R == 0) i_rep = 1;
        end
      end
      s2 = s1;
      s1 = ~btn_in;
    end
  end

  int ecnt = 0;
  always @(posedge clock) ecnt++;

  // Compare process plus event bookkeeping for the directed checks.
  int npress = 0, nrel = 0, nrep = 0;
  int press_edge = -1, rel_edge = -1, long_edge = -1, rep_first = -1, rep_second = -1;
  bit prev_long = 0;
  always @(negedge clock) begin
    chk("press_pulse",   press_pulse,   e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("repeat_pulse",  repeat_pulse,  e_rep);
    chk("held",          held,          e_held);
    chk("long_press",    long_press,    e_long);
    if (press_pulse === 1'b1) begin
      npress++; press_edge = ecnt; rep_first = -1; rep_second = -1;
    end
    if (release_pulse === 1'b1) begin nrel++; rel_edge = ecnt; end
    if (repeat_pulse === 1'b1) begin
      nrep++;
      if (rep_first < 0) rep_first = ecnt;
      else if (rep_second < 0) rep_second = ecnt;
    end
    if (long_press === 1'b1 && !prev_long) long_edge = ecnt;
    prev_long = (long_press === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int e0, np0, nr0, len;

  initial begin
    reset_n = 1'b0;
    btn_in  = 1'b1;
    step(3);
    reset_n = 1'b1;
    chk("reset_outputs", {press_pulse, release_pulse, held, long_press, repeat_pulse}, 0);

    // idle, nothing should happen
    step(50);
    chk("idle_press_cnt", npress, 0);
    chk("idle_rel_cnt",   nrel,   0);
    chk("idle_rep_cnt",   nrep,   0);

    // clean press and release
    btn_in = 1'b0; e0 = ecnt + 1;
    step(30);
    chk("press_latency", press_edge, e0 + 7);
    chk("held_after_press", held, 1);
    btn_in = 1'b1; e0 = ecnt + 1;
    step(20);
    chk("release_latency", rel_edge, e0 + 7);
    chk("held_after_release", held, 0);

    // bouncing input
    np0 = npress; nr0 = nrel;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    btn_in = 1'b1;
    step(15);
    chk("bounce_no_press",   npress, np0);
    chk("bounce_no_release", nrel,   nr0);

    // long press and auto-repeat
    btn_in = 1'b0;
    step(60);
    chk("long_after_press",  long_edge - press_edge, 20);
    chk("first_repeat_edge", rep_first, long_edge);
    chk("second_repeat_gap", rep_second - long_edge, 5);
    chk("long_level",        long_press, 1);

    // short release glitch while held
    nr0 = nrel;
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(30);
    chk("glitch_no_release", nrel, nr0);
    chk("glitch_still_held", held, 1);
    btn_in = 1'b1;
    step(15);
    chk("release_after_long", nrel, nr0 + 1);
    chk("long_cleared",       long_press, 0);

    // reset while long_press is set
    btn_in = 1'b0;
    step(35);
    chk("long_before_reset", long_press, 1);
    nr0 = nrel;
    @(posedge clock); #3 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {press_pulse, release_pulse, held, long_press, repeat_pulse}, 0);
    @(posedge clock); #3 reset_n = 1'b1;
    e0 = ecnt + 1;
    step(15);
    chk("repress_after_reset", press_edge, e0 + 7);
    chk("no_release_on_reset", nrel, nr0);
    btn_in = 1'b1;
    step(15);

    // random activity with occasional resets
    for (int i = 0; i < 120; i++) begin
      btn_in = ~btn_in;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 60);
      else len = $urandom_range(1, 10);
      step(len);
      if ($urandom_range(0, 14) == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clock); #3 reset_n = 1'b1;
      end
    end
    btn_in = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
